// File: rtl/pmod_ad1_pkg.sv
// Shared definitions for the PmodAD1 (AD7476A-style) serial ADC receiver.
package pmod_ad1_pkg;

    typedef enum logic [1:0] {
        StQuiet,
        StShift,
        StDone
    } state_t;

    localparam int unsigned FrameLen = 16;   // SClk periods / bits per conversion frame
    localparam int unsigned SampleW  = 12;   // payload bits at the bottom of the frame
    localparam int unsigned OutW     = 29;   // Q8.20 output width
    localparam int unsigned Midscale = 2048; // offset-binary zero point

    // Offset-binary sample to a signed, sign-extended value scaled by 2^frac_shift.
    function automatic logic [OutW-1:0] centre_and_scale(input logic [SampleW-1:0] u,
                                                         input int unsigned frac_shift);
        logic [SampleW-1:0] s;
        logic [OutW-1:0]    ext;
        s   = u - SampleW'(Midscale);
        ext = {{(OutW - SampleW){s[SampleW-1]}}, s};
        return ext << frac_shift;
    endfunction

endpackage

// File: rtl/pmod_ad1_if.sv
// ADC-side serial pins plus the sample output of the PmodAD1 receiver.
interface pmod_ad1_if;
    import pmod_ad1_pkg::*;

    logic            sdatain;
    logic            SClk;
    logic            CS;
    logic [OutW-1:0] dataout;
    logic            rx_done;

    // master: the receiver; slave: the ADC and the sample consumer.
    modport master (input sdatain, output SClk, output CS, output dataout, output rx_done);
    modport slave  (output sdatain, input SClk, input CS, input dataout, input rx_done);

endinterface

// File: rtl/pmod_ad1_sclk_gen.sv
// SClk divider: idles high while disabled, toggles every SCLK_HALF clk while enabled,
// and flags the clk edge on which SClk is about to fall or rise.
module pmod_ad1_sclk_gen #(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic clk,
    input  logic Reset,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int unsigned CntW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    logic [CntW-1:0] cnt;
    logic            half_end;

    assign half_end = en && (cnt == CntW'(SCLK_HALF - 1));
    assign rise     = half_end && !sclk;
    assign fall     = half_end && sclk;

    // Half-period counter and registered SClk; disabling restarts from a high phase.
    always_ff @(posedge clk) begin
        if (Reset || !en) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (half_end) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pmod_ad1.sv
// PmodAD1 receiver: free-running AD7476A-style conversions, each 12-bit offset-binary
// sample centred on midscale and presented as a signed Q8.20 word with a done pulse.
module pmod_ad1
    import pmod_ad1_pkg::*;
#(
    parameter int unsigned SCLK_HALF  = 2,
    parameter int unsigned QUIET_CYC  = 8,
    parameter int unsigned FRAC_SHIFT = 9
) (
    input  logic          clk,
    input  logic          Reset,
    pmod_ad1_if.master    bus
);

    localparam int unsigned QuietW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
    localparam int unsigned FallW  = $clog2(FrameLen + 1);

    state_t              state;
    logic [QuietW-1:0]   quiet_cnt;
    logic [FallW-1:0]    fall_cnt;
    // Only the low 12 frame bits survive; the four leading zeros shift out of the top.
    logic [SampleW-1:0]  shreg;
    logic                cs_q;
    logic [OutW-1:0]     dataout_q;
    logic                rx_done_q;

    logic                shift_en;
    logic                sclk;
    logic                sclk_rise;
    logic                sclk_fall;

    assign shift_en = (state == StShift);

    pmod_ad1_sclk_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk_gen (
        .clk   (clk),
        .Reset (Reset),
        .en    (shift_en),
        .sclk  (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // Frame sequencer: quiet gap, 16-bit shift on SClk rises, one-cycle output update.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= StQuiet;
            quiet_cnt <= '0;
            fall_cnt  <= '0;
            shreg     <= '0;
            cs_q      <= 1'b1;
            dataout_q <= '0;
            rx_done_q <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            unique case (state)
                StQuiet: begin
                    cs_q <= 1'b1;
                    if (quiet_cnt == QuietW'(QUIET_CYC - 1)) begin
                        quiet_cnt <= '0;
                        fall_cnt  <= '0;
                        cs_q      <= 1'b0;
                        state     <= StShift;
                    end else begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                end
                StShift: begin
                    if (sclk_fall) begin
                        fall_cnt <= fall_cnt + 1'b1;
                    end
                    // Data was launched on the preceding fall, so it is stable on the rise.
                    if (sclk_rise) begin
                        shreg <= {shreg[SampleW-2:0], bus.sdatain};
                        // The rise that follows the last fall carries the final bit.
                        if (fall_cnt == FallW'(FrameLen)) begin
                            cs_q  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    dataout_q <= centre_and_scale(shreg, FRAC_SHIFT);
                    rx_done_q <= 1'b1;
                    state     <= StQuiet;
                end
                default: begin
                    state <= StQuiet;
                end
            endcase
        end
    end

    assign bus.SClk    = sclk;
    assign bus.CS      = cs_q;
    assign bus.dataout = dataout_q;
    assign bus.rx_done = rx_done_q;

endmodule

// File: tb/tb_pmod_ad1.sv
// Bench for pmod_ad1: an ADC model serves queued frame words, tasks compare the
// received samples, timing and pin behaviour against an arithmetic reference.
module tb_pmod_ad1;

    localparam int unsigned SCLK_HALF  = 2;
    localparam int unsigned QUIET_CYC  = 8;
    localparam int unsigned FRAC_SHIFT = 9;
    // Quiet gap + 16 SClk periods + one done cycle.
    localparam int unsigned FRAME      = QUIET_CYC + 2 * 16 * SCLK_HALF + 1;

    logic        clk;
    logic        Reset;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    pmod_ad1_if bus ();

    pmod_ad1 #(
        .SCLK_HALF  (SCLK_HALF),
        .QUIET_CYC  (QUIET_CYC),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: a word is taken from the queue when CS falls and shifted out MSB
    // first, one bit after each SClk fall. An empty queue yields a zero frame.
    logic [15:0] word_q[$];
    int          fall_log[$];
    logic [15:0] cur_word = 16'h0000;
    int          bit_idx  = -1;
    int          falls    = 0;

    always @(negedge bus.CS) begin
        if (word_q.size() > 0) cur_word = word_q.pop_front();
        else cur_word = 16'h0000;
        bit_idx = 15;
        falls   = 0;
    end

    always @(posedge bus.CS) fall_log.push_back(falls);

    always @(negedge bus.SClk) begin
        if (bus.CS === 1'b0) begin
            falls++;
            if (bit_idx >= 0) begin
                bus.sdatain = cur_word[bit_idx];
                bit_idx--;
            end
        end
    end

    // Reference: low 12 bits offset-binary, minus midscale, times 2^FRAC_SHIFT, 29 bits.
    function automatic logic [28:0] ref_out(input logic [15:0] w);
        longint u;
        longint s;
        u = longint'(w) % 4096;
        s = (u - 2048) * (longint'(1) << FRAC_SHIFT);
        return s[28:0];
    endfunction

    task automatic wait_rx(input int limit, output bit seen, output int n);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.rx_done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int n;
        bit fell;
        Reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.CS !== 1'b1) begin
            errors++;
            $display("FAIL reset_cs: got %b expected 1", bus.CS);
        end
        checks++;
        if (bus.SClk !== 1'b1) begin
            errors++;
            $display("FAIL reset_sclk: got %b expected 1", bus.SClk);
        end
        checks++;
        if (bus.rx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_done: got %b expected 0", bus.rx_done);
        end
        checks++;
        if (bus.dataout !== 29'h0) begin
            errors++;
            $display("FAIL reset_dataout: got %h expected 0", bus.dataout);
        end
        @(negedge clk);
        Reset = 1'b0;
        n    = 0;
        fell = 1'b0;
        while (!fell && n < 4 * FRAME) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.CS === 1'b0) fell = 1'b1;
        end
        checks++;
        if (!fell || n != QUIET_CYC) begin
            errors++;
            $display("FAIL reset_first_cs_fall: got %0d cycles (fell=%b) expected %0d",
                     n, fell, QUIET_CYC);
        end
    endtask

    task automatic test_directed();
        logic [15:0] words [5];
        logic [28:0] expv  [5];
        bit          seen;
        int          n;
        words = '{16'h0FFF, 16'h0800, 16'h0000, 16'h0001, 16'hF800};
        expv  = '{29'h000FFE00, 29'h00000000, 29'h1FF00000, 29'h1FF00200, 29'h00000000};
        wait_rx(2 * FRAME, seen, n);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL directed_sync: got no rx_done expected one");
        end
        for (int i = 0; i < 5; i++) begin
            word_q.push_back(words[i]);
            wait_rx(2 * FRAME, seen, n);
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL directed_rx_done word %h: got none expected pulse", words[i]);
            end else if (bus.dataout !== expv[i]) begin
                errors++;
                $display("FAIL directed_dataout word %h: got %h expected %h",
                         words[i], bus.dataout, expv[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.rx_done !== 1'b0) begin
                errors++;
                $display("FAIL rx_done_width: got %b expected 0 one cycle later", bus.rx_done);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] w;
        bit          seen;
        int          n;
        wait_rx(2 * FRAME, seen, n);
        for (int i = 0; i < 8; i++) begin
            w = 16'($urandom);
            word_q.push_back(w);
            wait_rx(2 * FRAME, seen, n);
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL random_rx_done word %h: got none expected pulse", w);
            end else if (bus.dataout !== ref_out(w)) begin
                errors++;
                $display("FAIL random_dataout word %h: got %h expected %h",
                         w, bus.dataout, ref_out(w));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [4];
        bit          seen;
        int          n;
        int unsigned last;
        int          f;
        wait_rx(2 * FRAME, seen, n);
        fall_log.delete();
        for (int k = 0; k < 4; k++) begin
            words[k] = 16'($urandom_range(0, 4095));
            word_q.push_back(words[k]);
        end
        last = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_rx(2 * FRAME, seen, n);
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL b2b_rx_done frame %0d: got none expected pulse", k);
            end else if (bus.dataout !== ref_out(words[k])) begin
                errors++;
                $display("FAIL b2b_dataout frame %0d: got %h expected %h",
                         k, bus.dataout, ref_out(words[k]));
            end
            if (k > 0) begin
                checks++;
                if (cyc - last != FRAME) begin
                    errors++;
                    $display("FAIL b2b_interval frame %0d: got %0d expected %0d",
                             k, cyc - last, FRAME);
                end
            end
            last = cyc;
            f = (fall_log.size() > 0) ? fall_log.pop_front() : -1;
            checks++;
            if (f != 16) begin
                errors++;
                $display("FAIL b2b_sclk_falls frame %0d: got %0d expected 16", k, f);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] w;
        bit          seen;
        int          n;
        int          f;
        wait_rx(2 * FRAME, seen, n);
        word_q.push_back(16'($urandom));
        n = 0;
        while (!(bus.CS === 1'b0 && falls >= 8) && n < 2 * FRAME) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 2 * FRAME) begin
            errors++;
            $display("FAIL midframe_reach_bit8: got timeout expected bit 8 in flight");
        end
        Reset = 1'b1;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        checks++;
        if (bus.CS !== 1'b1 || bus.SClk !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pins: got CS=%b SClk=%b expected 1 1", bus.CS, bus.SClk);
        end
        checks++;
        if (bus.rx_done !== 1'b0 || bus.dataout !== 29'h0) begin
            errors++;
            $display("FAIL midframe_outputs: got rx_done=%b dataout=%h expected 0 0",
                     bus.rx_done, bus.dataout);
        end
        word_q.delete();
        fall_log.delete();
        w = 16'($urandom);
        word_q.push_back(w);
        wait_rx(2 * FRAME, seen, n);
        checks++;
        if (!seen || n != FRAME) begin
            errors++;
            $display("FAIL midframe_next_frame_time: got %0d cycles (seen=%b) expected %0d",
                     n, seen, FRAME);
        end
        checks++;
        if (bus.dataout !== ref_out(w)) begin
            errors++;
            $display("FAIL midframe_next_dataout word %h: got %h expected %h",
                     w, bus.dataout, ref_out(w));
        end
        f = (fall_log.size() > 0) ? fall_log.pop_front() : -1;
        checks++;
        if (f != 16) begin
            errors++;
            $display("FAIL midframe_sclk_falls: got %0d expected 16", f);
        end
    endtask

    task automatic test_protocol();
        logic prev_cs;
        prev_cs = bus.CS;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (prev_cs === 1'b1 && bus.CS === 1'b0) begin
                checks++;
                if (bus.SClk !== 1'b1) begin
                    errors++;
                    $display("FAIL proto_cs_fall: got SClk=%b expected 1", bus.SClk);
                end
            end
            if (bus.CS === 1'b1) begin
                checks++;
                if (bus.SClk !== 1'b1) begin
                    errors++;
                    $display("FAIL proto_idle_sclk: got SClk=%b expected 1 while CS high",
                             bus.SClk);
                end
            end
            prev_cs = bus.CS;
        end
    endtask

    initial begin
        Reset       = 1'b1;
        bus.sdatain = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midframe();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
